// File: rtl/cbfp_denorm.sv
// cbfp_denorm: final CBFP de-normalisation stage at the FFT output.
// Two-stage valid/ready pipeline. S1 captures the sample and the summed
// shift index. S2 applies (x <<< SHIFT_BIAS) >>> S and fits the result
// to BW_OUT bits. A frame counter drives out_last, and sat_flag is a
// sticky out-of-range indicator.
// Optional feature macro: CBFP_DENORM_SAT_EN.
//   Defined:   out-of-range results clamp to the BW_OUT signed limits.
//   Undefined: out-of-range results wrap (two's complement).
//              sat_flag still reports the wrap events.
module cbfp_denorm #(
  parameter int N          = 512,
  parameter int BW_IN      = 13,
  parameter int BW_OUT     = 16,
  parameter int BW_IDX     = 5,
  parameter int SHIFT_BIAS = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BW_IN-1:0]  in_re,
  input  logic [BW_IN-1:0]  in_im,
  input  logic [BW_IDX-1:0] in_idx0,
  input  logic [BW_IDX-1:0] in_idx1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW_OUT-1:0] out_re,
  output logic [BW_OUT-1:0] out_im,
  output logic              out_last,
  output logic              sat_flag,
  input  logic              clr_sat
);

  localparam int BW_W   = BW_IN + SHIFT_BIAS;
  localparam int BW_S   = BW_IDX + 1;
  localparam int BW_CNT = $clog2(N);
  localparam logic [BW_S-1:0]   S_LIM    = BW_S'(BW_W);
  localparam logic [BW_CNT-1:0] CNT_LAST = BW_CNT'(N - 1);
  localparam logic [BW_CNT-1:0] CNT_ONE  = {{(BW_CNT-1){1'b0}}, 1'b1};

  // Pre-shift left by SHIFT_BIAS, then shift right arithmetically by s.
  // Shifts of the full width or more collapse to the sign (0 or -1).
  function automatic logic [BW_W-1:0] denorm_shift(input logic [BW_IN-1:0] x,
                                                   input logic [BW_S-1:0]  s);
    logic signed [BW_W-1:0] w;
    w = $signed({x, {SHIFT_BIAS{1'b0}}});
    if (s >= S_LIM) begin
      w = {BW_W{w[BW_W-1]}};
    end else begin
      w = w >>> s;
    end
    return w;
  endfunction

  // The value fits in BW_OUT only when every bit from BW_OUT-1 upward matches the sign.
  function automatic logic out_of_range(input logic [BW_W-1:0] w);
    logic [BW_W-BW_OUT:0] top;
    top = w[BW_W-1:BW_OUT-1];
    return !((&top) || !(|top));
  endfunction

  // Reduce the wide value to BW_OUT bits, either by clamping or by wrapping.
  function automatic logic [BW_OUT-1:0] fit_out(input logic [BW_W-1:0] w);
`ifdef CBFP_DENORM_SAT_EN
    if (out_of_range(w)) begin
      if (w[BW_W-1]) begin
        return {1'b1, {(BW_OUT-1){1'b0}}};
      end else begin
        return {1'b0, {(BW_OUT-1){1'b1}}};
      end
    end else begin
      return w[BW_OUT-1:0];
    end
`else
    return w[BW_OUT-1:0];
`endif
  endfunction

  logic              s1_valid_q, s1_valid_d;
  logic [BW_IN-1:0]  s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic [BW_S-1:0]   s1_s_q, s1_s_d;
  logic              s2_valid_q, s2_valid_d;
  logic [BW_OUT-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic [BW_CNT-1:0] cnt_q, cnt_d;
  logic              sat_q, sat_d;
  logic              s1_ld, s2_ld, out_xfer, sat_set;
  logic [BW_W-1:0]   w_re, w_im;

  // Handshake decisions and next state for both stages, the counter and the sticky flag.
  always_comb begin
    out_xfer   = s2_valid_q && out_ready;
    s2_ld      = !s2_valid_q || out_ready;
    s1_ld      = !s1_valid_q || s2_ld;
    w_re       = denorm_shift(s1_re_q, s1_s_q);
    w_im       = denorm_shift(s1_im_q, s1_s_q);
    sat_set    = s2_ld && s1_valid_q && (out_of_range(w_re) || out_of_range(w_im));
    s1_valid_d = s1_valid_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    s1_s_d     = s1_s_q;
    s2_valid_d = s2_valid_q;
    s2_re_d    = s2_re_q;
    s2_im_d    = s2_im_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;

    if (s1_ld) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_re_d = in_re;
        s1_im_d = in_im;
        s1_s_d  = {1'b0, in_idx0} + {1'b0, in_idx1};
      end else begin
        s1_s_d = s1_s_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_ld) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_re_d = fit_out(w_re);
        s2_im_d = fit_out(w_im);
      end else begin
        s2_re_d = s2_re_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (out_xfer) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end

    // A new saturation event takes priority over a clear in the same cycle.
    if (sat_set) begin
      sat_d = 1'b1;
    end else if (clr_sat) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  // State registers; reset empties the pipeline and restarts the frame count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= {BW_IN{1'b0}};
      s1_im_q    <= {BW_IN{1'b0}};
      s1_s_q     <= {BW_S{1'b0}};
      s2_valid_q <= 1'b0;
      s2_re_q    <= {BW_OUT{1'b0}};
      s2_im_q    <= {BW_OUT{1'b0}};
      cnt_q      <= {BW_CNT{1'b0}};
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s1_s_q     <= s1_s_d;
      s2_valid_q <= s2_valid_d;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
    end
  end

  assign in_ready  = s1_ld;
  assign out_valid = s2_valid_q;
  assign out_re    = s2_re_q;
  assign out_im    = s2_im_q;
  assign out_last  = s2_valid_q && (cnt_q == CNT_LAST);
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_cbfp_denorm.sv
// Directed bench for cbfp_denorm. It keeps a queue of expected outputs that
// is drained on each output transfer, and it tracks the frame position so
// it can check out_last.
module tb_cbfp_denorm;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [12:0] in_re = 13'd0;
  logic [12:0] in_im = 13'd0;
  logic [4:0]  in_idx0 = 5'd0;
  logic [4:0]  in_idx1 = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_re;
  logic [15:0] out_im;
  logic        out_last;
  logic        sat_flag;
  logic        clr_sat = 1'b0;

  typedef struct {int re; int im;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;
  int mcnt = 0;
  int n_last = 0;

  cbfp_denorm dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_idx0(in_idx0), .in_idx1(in_idx1),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .sat_flag(sat_flag), .clr_sat(clr_sat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Expected output: (x * 2^12) >> s (floor), then clamp or 16-bit wrap.
  function automatic int model(input int x, input int s);
    int v;
    v = (x * 4096) >>> s;
`ifdef CBFP_DENORM_SAT_EN
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
`else
    begin
      logic [31:0] t;
      t = v;
      v = int'($signed(t[15:0]));
    end
`endif
    return v;
  endfunction

  // Output monitor: checks each output transfer against the queue, in order.
  always @(negedge clk) begin
    #3;
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check_val("spurious_out", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check_val("out_re", int'($signed(out_re)), mon_e.re);
        check_val("out_im", int'($signed(out_im)), mon_e.im);
        check_val("out_last", int'(out_last), (mcnt == 511) ? 1 : 0);
        if (out_last) n_last++;
        mcnt = (mcnt + 1) % 512;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the input transfer.
  task automatic send(input int re, input int im, input int i0, input int i1,
                      input int ere, input int eim);
    int k;
    exp_t e;
    in_valid = 1'b1;
    in_re = 13'(re);
    in_im = 13'(im);
    in_idx0 = 5'(i0);
    in_idx1 = 5'(i1);
    e.re = ere;
    e.im = eim;
    q.push_back(e);
    k = 0;
    #3;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      #3;
      k++;
    end
    if (k >= 100) check_val("send_timeout", k, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    q.delete();
    mcnt = 0;
    #1;
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_in_ready", int'(in_ready), 1);
    check_val("rst_out_last", int'(out_last), 0);
    check_val("rst_sat_flag", int'(sat_flag), 0);
    check_val("rst_out_re", int'(out_re), 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check_val("drain_left", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int re_i, im_i, a_i, b_i;
    @(negedge clk);
    do_reset();

    // 1: basic de-normalisation and the two-cycle latency
    send(100, -100, 3, 2, 12800, -12800);
    check_val("lat_early", int'(out_valid), 0);
    @(negedge clk);
    check_val("lat_valid", int'(out_valid), 1);
    check_val("t1_re", int'($signed(out_re)), 12800);
    check_val("t1_sat", int'(sat_flag), 0);

    // 2: positive overflow, clear, then set winning over clear
`ifdef CBFP_DENORM_SAT_EN
    send(1023, 0, 0, 0, 32767, 0);
`else
    send(1023, 0, 0, 0, -4096, 0);
`endif
    @(negedge clk);
    check_val("t2_sat_set", int'(sat_flag), 1);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    #1;
    check_val("t2_sat_clr", int'(sat_flag), 0);
    @(negedge clk);
`ifdef CBFP_DENORM_SAT_EN
    send(-1024, 0, 0, 0, -32768, 0);
`else
    send(-1024, 0, 0, 0, 0, 0);
`endif
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;
    #1;
    check_val("t2_set_wins", int'(sat_flag), 1);
    @(negedge clk);
    clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0;

    // 3: very large shifts floor toward -inf; near-limit values stay in range
    send(-1, 1, 10, 10, -1, 0);
    send(1, -1, 10, 10, 0, -1);
    send(4095, -4096, 5, 5, 16380, -16384);
    send(4095, 7, 31, 31, 0, 0);
    drain();
    check_val("t3_sat", int'(sat_flag), 0);

    // 4: stall downstream; the third input must wait and order is preserved
    out_ready = 1'b0;
    send(8, 16, 1, 1, 8192, 16384);
    send(-8, 2, 2, 2, -2048, 512);
    fork
      send(3, -5, 4, 0, 768, -1280);
      begin
        repeat (5) @(negedge clk);
        #1;
        check_val("t4_in_ready", int'(in_ready), 0);
        check_val("t4_out_valid", int'(out_valid), 1);
        check_val("t4_hold_re", int'($signed(out_re)), 8192);
        out_ready = 1'b1;
      end
    join
    drain();

    // 5: two full frames back to back, out_last only on outputs 511 and 1023
    @(negedge clk);
    do_reset();
    n_last = 0;
    for (int i = 0; i < 1024; i++) begin
      re_i = ((i * 37) % 8192) - 4096;
      im_i = 4095 - ((i * 53) % 8192);
      a_i = i % 8;
      b_i = (i / 3) % 16;
      send(re_i, im_i, a_i, b_i, model(re_i, a_i + b_i), model(im_i, a_i + b_i));
    end
    drain();
    check_val("t5_last_count", n_last, 2);

    // 6: reset in the middle of a frame, then a full frame
    for (int i = 0; i < 200; i++) begin
      send(i, -i, 2, 3, model(i, 5), model(-i, 5));
    end
    do_reset();
    n_last = 0;
    for (int i = 0; i < 512; i++) begin
      re_i = (i * 11) % 4096;
      send(re_i, -re_i, 1, 2, model(re_i, 3), model(-re_i, 3));
    end
    drain();
    check_val("t6_last_count", n_last, 1);
    check_val("t6_cnt_wrap", mcnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
